// File: rtl/tdm_demux_pkg.sv
// Shared constants and state type for the TDM receive demux.
// TDM_DEMUX_PARITY_EN extends the frame with an even-parity slot.
package tdm_demux_pkg;
  localparam int NUM_CH = 4;
`ifdef TDM_DEMUX_PARITY_EN
  localparam int FRAME_LEN = 5;
`else
  localparam int FRAME_LEN = 4;
`endif
  localparam int SLOT_W = 3;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FRAME_LEN - 1);

  typedef enum logic {IDLE, LOCK} state_t;
endpackage

// File: rtl/tdm_slot_counter.sv
// Slot index for the TDM demux: advance/wrap, realign to slot 1 on sync, clear.
module tdm_slot_counter
  import tdm_demux_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              adv,
  input  logic              realign,
  input  logic              clear,
  output logic [SLOT_W-1:0] slot
);

  // realign means the current en cycle was consumed as slot 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          slot <= '0;
    else if (clear)   slot <= '0;
    else if (realign) slot <= SLOT_W'(1);
    else if (adv)     slot <= (slot == LAST_SLOT) ? '0 : slot + 1'b1;
  end

endmodule

// File: rtl/tdm_1_to_4_demux.sv
// TDM receive demux: locks to sync, gathers slot bits into a frame word.
// TDM_DEMUX_PARITY_EN adds a parity slot and the parity_err output.
module tdm_1_to_4_demux
  import tdm_demux_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  input  logic              sync,
  input  logic              en,
  output logic [NUM_CH-1:0] out,
  output logic              valid,
  output logic [SLOT_W-1:0] slot,
  output logic              locked,
  output logic              sync_err
`ifdef TDM_DEMUX_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  state_t                 state;
  logic [FRAME_LEN-2:0]   shadow;
  logic [CW-1:0]          idle_cnt;
  logic                   realign, adv, timeout_hit, clear;

  assign realign     = en & sync & ((state == IDLE) | (slot != '0));
  assign adv         = en & (state == LOCK) & ~realign;
  assign timeout_hit = (TIMEOUT != 0) && (idle_cnt == TO_LAST);
  assign clear       = (state == LOCK) & ~en & timeout_hit;
  assign locked      = (state == LOCK);

  tdm_slot_counter u_slot (
    .clk     (clk),
    .rst     (rst),
    .adv     (adv),
    .realign (realign),
    .clear   (clear),
    .slot    (slot)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shadow   <= '0;
      idle_cnt <= '0;
      out      <= '0;
      valid    <= 1'b0;
      sync_err <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      valid    <= 1'b0;
      sync_err <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          idle_cnt <= '0;
          if (en && sync) begin
            shadow[0] <= din;
            state     <= LOCK;
          end
        end
        LOCK: begin
          if (en) begin
            idle_cnt <= '0;
            if (realign) begin
              // misplaced sync: drop the partial frame, this bit is slot 0
              sync_err  <= 1'b1;
              shadow[0] <= din;
            end else begin
              for (int i = 0; i < FRAME_LEN - 1; i++)
                if (slot == SLOT_W'(i)) shadow[i] <= din;
              if (slot == LAST_SLOT) begin
                valid <= 1'b1;
`ifdef TDM_DEMUX_PARITY_EN
                out        <= shadow[NUM_CH-1:0];
                parity_err <= ^{din, shadow};
`else
                out        <= {din, shadow};
`endif
              end
            end
          end else if (timeout_hit) begin
            state    <= IDLE;
            idle_cnt <= '0;
          end else if (TIMEOUT != 0) begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tdm_1_to_4_demux.sv
// Directed bench for tdm_1_to_4_demux (default 4-slot build, TIMEOUT=16).
module tb_tdm_1_to_4_demux;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b0;
  logic       sync = 1'b0;
  logic       en = 1'b0;
  logic [3:0] out;
  logic       valid;
  logic [2:0] slot;
  logic       locked;
  logic       sync_err;

  int checks = 0;
  int errors = 0;
  logic [3:0] sb[$];

  tdm_1_to_4_demux #(.TIMEOUT(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .sync     (sync),
    .en       (en),
    .out      (out),
    .valid    (valid),
    .slot     (slot),
    .locked   (locked),
    .sync_err (sync_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; sampled 1 time unit after the edge.
  task automatic step(input logic e, input logic s, input logic d,
                      input logic exp_valid, input logic exp_err, input string tag);
    logic [3:0] exp_out;
    @(negedge clk);
    en = e; sync = s; din = d;
    @(posedge clk);
    #1;
    chk({tag, "_valid"}, 8'(valid), 8'(exp_valid));
    chk({tag, "_sync_err"}, 8'(sync_err), 8'(exp_err));
    if (valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk({tag, "_unexpected_frame"}, 8'(1), 8'(0));
      end else begin
        exp_out = sb.pop_front();
        chk({tag, "_out"}, 8'(out), 8'(exp_out));
      end
    end
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out", 8'(out), 8'h0);
    chk("rst_valid", 8'(valid), 8'h0);
    chk("rst_slot", 8'(slot), 8'h0);
    chk("rst_locked", 8'(locked), 8'h0);
    chk("rst_sync_err", 8'(sync_err), 8'h0);

    // IDLE ignores sync without en and en without sync
    step(0, 1, 1, 0, 0, "idle_sync_only");
    chk("idle_sync_only_locked", 8'(locked), 8'h0);
    step(1, 0, 1, 0, 0, "idle_en_only");
    chk("idle_en_only_locked", 8'(locked), 8'h0);

    // first frame 1,0,1,1
    step(1, 1, 1, 0, 0, "f1_s0");
    chk("f1_s0_slot", 8'(slot), 8'h1);
    chk("f1_s0_locked", 8'(locked), 8'h1);
    step(1, 0, 0, 0, 0, "f1_s1");
    chk("f1_s1_slot", 8'(slot), 8'h2);
    step(1, 0, 1, 0, 0, "f1_s2");
    chk("f1_s2_slot", 8'(slot), 8'h3);
    sb.push_back(4'b1101);
    step(1, 0, 1, 1, 0, "f1_s3");
    chk("f1_slot_wrap", 8'(slot), 8'h0);
    chk("f1_locked", 8'(locked), 8'h1);
    step(0, 0, 0, 0, 0, "f1_valid_drop");
    chk("f1_out_hold", 8'(out), 8'hd);

    // back-to-back frames, sync only on the first
    step(1, 1, 0, 0, 0, "f2_s0");
    step(1, 0, 1, 0, 0, "f2_s1");
    step(1, 0, 1, 0, 0, "f2_s2");
    sb.push_back(4'b0110);
    step(1, 0, 0, 1, 0, "f2_s3");
    step(1, 0, 1, 0, 0, "f3_s0");
    step(1, 0, 1, 0, 0, "f3_s1");
    step(1, 0, 1, 0, 0, "f3_s2");
    sb.push_back(4'b1111);
    step(1, 0, 1, 1, 0, "f3_s3");

    // misplaced sync at slot 2
    step(1, 1, 1, 0, 0, "mis_s0");
    step(1, 0, 0, 0, 0, "mis_s1");
    chk("mis_pre_slot", 8'(slot), 8'h2);
    step(1, 1, 1, 0, 1, "mis_sync");
    chk("mis_slot", 8'(slot), 8'h1);
    chk("mis_locked", 8'(locked), 8'h1);
    chk("mis_out_hold", 8'(out), 8'hf);
    step(1, 0, 1, 0, 0, "re_s1");
    step(1, 0, 0, 0, 0, "re_s2");
    sb.push_back(4'b0011);
    step(1, 0, 0, 1, 0, "re_s3");

    // en gaps mid-frame under the timeout
    step(1, 1, 1, 0, 0, "gap_s0");
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, "gap_idle");
    step(1, 0, 1, 0, 0, "gap_s1");
    step(0, 0, 0, 0, 0, "gap_idle2");
    step(1, 0, 1, 0, 0, "gap_s2");
    sb.push_back(4'b0111);
    step(1, 0, 0, 1, 0, "gap_s3");

    // timeout after slot 1
    step(1, 1, 0, 0, 0, "to_s0");
    for (int i = 1; i <= 15; i++) step(0, 0, 0, 0, 0, "to_wait");
    chk("to_locked_15", 8'(locked), 8'h1);
    step(0, 0, 0, 0, 0, "to_16");
    chk("to_locked_16", 8'(locked), 8'h0);
    chk("to_slot", 8'(slot), 8'h0);
    chk("to_out_hold", 8'(out), 8'h7);
    for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 0, "to_ignored");
    chk("to_still_unlocked", 8'(locked), 8'h0);
    chk("to_slot_after", 8'(slot), 8'h0);

    // async reset mid-frame
    step(1, 1, 1, 0, 0, "ar_s0");
    step(1, 0, 1, 0, 0, "ar_s1");
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("ar_out", 8'(out), 8'h0);
    chk("ar_slot", 8'(slot), 8'h0);
    chk("ar_locked", 8'(locked), 8'h0);
    chk("ar_valid", 8'(valid), 8'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 0, "ar_after");
    chk("ar_after_locked", 8'(locked), 8'h0);
    chk("ar_after_out", 8'(out), 8'h0);

    chk("sb_drained", 8'(sb.size()), 8'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
